// File: rtl/fetch_unit.sv
// Program counter and IF/ID pipeline register feeding decode from instruction memory.
// Optional macro FETCH_PERF_EN adds a saturating 16-bit count of valid fetches.
module fetch_unit #(
    parameter int unsigned           ADDR_W    = 11,
    parameter int unsigned           DATA_W    = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC  = '0,
    parameter logic [DATA_W-1:0]     NOP_INSTR = DATA_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_valid,
`ifdef FETCH_PERF_EN
    output logic [15:0]       fetch_count,
`endif
    output logic              halted
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   if_pc_d;
    logic [DATA_W-1:0]   if_instr_d;
    logic                if_valid_d;
    logic                halted_d;
    logic                fetch_c;

    assign imem_addr = pc_q;

    // State, PC and IF/ID registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            if_pc    <= '0;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            if_pc    <= if_pc_d;
            if_instr <= if_instr_d;
            if_valid <= if_valid_d;
            halted   <= halted_d;
        end
    end

    // Next-state and IF/ID update in priority order: halt, redirect, flush, stall, fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc;
        if_instr_d = if_instr;
        if_valid_d = if_valid;
        halted_d   = halted;
        fetch_c    = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (halt_req) begin
                    state_d    = HALT;
                    halted_d   = 1'b1;
                    if_instr_d = NOP_INSTR;
                    if_valid_d = 1'b0;
                end else if (branch_taken) begin
                    pc_d       = branch_target;
                    if_instr_d = NOP_INSTR;
                    if_valid_d = 1'b0;
                end else if (flush) begin
                    if_instr_d = NOP_INSTR;
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    if_instr_d = imem_data;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + ADDR_W'(1);
                    fetch_c    = 1'b1;
                end
            end
            HALT: begin
                halted_d   = 1'b1;
                if_instr_d = NOP_INSTR;
                if_valid_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating counter of edges that load a valid instruction.
    always_comb begin
        cnt_d = cnt_q;
        if (fetch_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_count = cnt_q;
`else
    logic unused_fetch;
    assign unused_fetch = fetch_c ^ (CNT_W == 0);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory word at address a is a+3 below 16, else a.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall, flush, branch_taken, halt_req;
    logic [10:0] branch_target;
    logic [10:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 11'd16) ? (32'(imem_addr) + 32'd3) : 32'(imem_addr);

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_valid     (if_valid),
`ifdef FETCH_PERF_EN
        .fetch_count  (fetch_count),
`endif
        .halted       (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 0; flush = 0; branch_taken = 0; halt_req = 0; branch_target = '0;
        tick(); tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0d exp=0", if_valid); end
        checks++; if (if_instr !== NOP) begin errors++; $display("FAIL rst_instr got=%h exp=%h", if_instr, NOP); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%0d exp=0", halted); end
        checks++; if (imem_addr !== 11'd0) begin errors++; $display("FAIL rst_addr got=%0d exp=0", imem_addr); end
        rst_n = 1'b1;
        tick();  // BOOT edge
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got=%0d exp=0", if_valid); end
        checks++; if (imem_addr !== 11'd0) begin errors++; $display("FAIL boot_addr got=%0d exp=0", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got=%0d exp=1", i, if_valid); end
            checks++; if (if_pc !== 11'(i)) begin errors++; $display("FAIL seq_pc[%0d] got=%0d exp=%0d", i, if_pc, i); end
            checks++; if (if_instr !== 32'(i + 3)) begin errors++; $display("FAIL seq_instr[%0d] got=%0d exp=%0d", i, if_instr, i + 3); end
            checks++; if (imem_addr !== 11'(i + 1)) begin errors++; $display("FAIL seq_addr[%0d] got=%0d exp=%0d", i, imem_addr, i + 1); end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (if_pc !== 11'd2 || if_instr !== 32'd5 || if_valid !== 1'b1)
                begin errors++; $display("FAIL stall_hold[%0d] got pc=%0d instr=%0d v=%0d exp pc=2 instr=5 v=1", i, if_pc, if_instr, if_valid); end
            checks++; if (imem_addr !== 11'd3) begin errors++; $display("FAIL stall_addr[%0d] got=%0d exp=3", i, imem_addr); end
        end
        stall = 1'b0;
        tick();
        checks++; if (if_pc !== 11'd3 || if_instr !== 32'd6) begin errors++; $display("FAIL stall_release got pc=%0d instr=%0d exp pc=3 instr=6", if_pc, if_instr); end
    endtask

    task automatic test_branch();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick(); tick(); tick();  // BOOT, pc0, pc1
        checks++; if (if_pc !== 11'd1) begin errors++; $display("FAIL br_setup got=%0d exp=1", if_pc); end
        stall = 1'b1; branch_taken = 1'b1; branch_target = 11'd20;
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        checks++; if (if_valid !== 1'b0 || if_instr !== NOP) begin errors++; $display("FAIL br_bubble got v=%0d instr=%h exp v=0 instr=%h", if_valid, if_instr, NOP); end
        checks++; if (imem_addr !== 11'd20) begin errors++; $display("FAIL br_addr got=%0d exp=20", imem_addr); end
        tick();
        checks++; if (if_pc !== 11'd20 || if_instr !== 32'd20 || if_valid !== 1'b1) begin errors++; $display("FAIL br_fetch got pc=%0d instr=%0d v=%0d exp 20/20/1", if_pc, if_instr, if_valid); end
    endtask

    task automatic test_flush();
        branch_taken = 1'b1; branch_target = 11'd5;
        tick();
        branch_taken = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_addr !== 11'd5) begin errors++; $display("FAIL flush_bubble got v=%0d addr=%0d exp v=0 addr=5", if_valid, imem_addr); end
        tick();
        checks++; if (if_pc !== 11'd5 || if_instr !== 32'd8 || if_valid !== 1'b1) begin errors++; $display("FAIL flush_refetch got pc=%0d instr=%0d v=%0d exp 5/8/1", if_pc, if_instr, if_valid); end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_target = 11'd2047;
        tick();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 11'd2047) begin errors++; $display("FAIL wrap_addr got=%0d exp=2047", imem_addr); end
        tick();
        checks++; if (if_pc !== 11'd2047 || if_instr !== 32'd2047) begin errors++; $display("FAIL wrap_fetch got pc=%0d instr=%0d exp 2047/2047", if_pc, if_instr); end
        checks++; if (imem_addr !== 11'd0) begin errors++; $display("FAIL wrap_zero got=%0d exp=0", imem_addr); end
        tick();
        checks++; if (if_pc !== 11'd0 || if_instr !== 32'd3) begin errors++; $display("FAIL wrap_next got pc=%0d instr=%0d exp 0/3", if_pc, if_instr); end
    endtask

    task automatic test_reset_run();
        branch_taken = 1'b1; branch_target = 11'd6;
        tick();
        branch_taken = 1'b0; flush = 1'b1;  // reset must override flush
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; flush = 1'b0;
        checks++; if (if_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 11'd0)
            begin errors++; $display("FAIL rrun got v=%0d h=%0d addr=%0d exp 0/0/0", if_valid, halted, imem_addr); end
        halt_req = 1'b1; branch_taken = 1'b1; branch_target = 11'd9;  // ignored in BOOT
        tick();
        halt_req = 1'b0; branch_taken = 1'b0;
        checks++; if (halted !== 1'b0 || imem_addr !== 11'd0) begin errors++; $display("FAIL boot_ignore got h=%0d addr=%0d exp 0/0", halted, imem_addr); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 11'd0) begin errors++; $display("FAIL boot_first got v=%0d pc=%0d exp 1/0", if_valid, if_pc); end
    endtask

    task automatic test_halt();
        halt_req = 1'b1; branch_taken = 1'b1; branch_target = 11'd30;
        tick();
        halt_req = 1'b0;
        checks++; if (halted !== 1'b1 || imem_addr !== 11'd1) begin errors++; $display("FAIL halt_enter got h=%0d addr=%0d exp 1/1", halted, imem_addr); end
        checks++; if (if_valid !== 1'b0 || if_instr !== NOP) begin errors++; $display("FAIL halt_bubble got v=%0d instr=%h exp 0/%h", if_valid, if_instr, NOP); end
        tick();
        branch_taken = 1'b0;
        checks++; if (halted !== 1'b1 || imem_addr !== 11'd1 || if_valid !== 1'b0) begin errors++; $display("FAIL halt_hold got h=%0d addr=%0d v=%0d exp 1/1/0", halted, imem_addr, if_valid); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 11'd0) begin errors++; $display("FAIL halt_reset got h=%0d v=%0d addr=%0d exp 0/0/0", halted, if_valid, imem_addr); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick();
        checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL perf_boot got=%0d exp=0", fetch_count); end
        for (int i = 0; i < 5; i++) tick();
        stall = 1'b1; tick(); tick(); stall = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (fetch_count !== 16'd10) begin errors++; $display("FAIL perf_count got=%0d exp=10", fetch_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_flush();
        test_wrap();
        test_reset_run();
        test_halt();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
